// File: rtl/drift_update_scheduler.sv
// Shared epoch timer, LFSR and round-robin force arbiter that sequences the
// per-oscillator drift random walks with one-hot, staggered update strobes.
module drift_update_scheduler #(
    parameter int          NUM_CH    = 4,
    parameter int          PERIOD    = 800,
    parameter logic [15:0] LFSR_SEED = 16'hC3A7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              freeze,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] force_req,
    output logic [NUM_CH-1:0] upd_stb,
    output logic [2:0]        upd_ch,
    output logic [7:0]        upd_rand,
    output logic              busy,
    output logic [15:0]       epoch_count,
    output logic              overrun
);
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [21:0] TLAST = 22'(PERIOD - 1);
    localparam logic [2:0]  LAST  = 3'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SEQ, FORCE} state_t;

    state_t              state_q, state_d;
    logic [21:0]         timer_q, timer_d;
    logic                pend_q, pend_d;
    logic                ovr_q, ovr_d;
    logic [NUM_CH-1:0]   fpend_q, fpend_d;
    logic [2:0]          rr_q, rr_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [NUM_CH-1:0]   stb_q, stb_d;
    logic [2:0]          ch_q, ch_d;
    logic [7:0]          rand_q, rand_d;
    logic [15:0]         ec_q, ec_d;

    logic                tick, wrap, seq_done, found;
    logic [2:0]          gnt;
    logic [NUM_CH-1:0]   clr;
    logic [7:0]          en_ext;
    logic [2*NUM_CH-1:0] rot;
    logic [15:0]         lfsr_nxt;

    assign tick     = clk_en && !freeze;
    assign wrap     = tick && (timer_q == TLAST);
    assign en_ext   = 8'(ch_enable);
    // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Rotate pending forces so bit 0 corresponds to rr_ptr, then take the first set bit.
    always_comb begin
        rot   = {fpend_q, fpend_q} >> rr_q;
        found = 1'b0;
        gnt   = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                gnt   = 3'((int'(rr_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rr_d     = rr_q;
        lfsr_d   = lfsr_q;
        stb_d    = '0;
        ch_d     = ch_q;
        rand_d   = rand_q;
        ec_d     = ec_q;
        seq_done = 1'b0;
        clr      = '0;
        timer_d  = timer_q;
        if (tick) timer_d = wrap ? 22'd0 : timer_q + 22'd1;

        case (state_q)
            IDLE: begin
                // A wrap in this cycle starts SEQ immediately so channel k strobes at T+2+k.
                if ((pend_q || wrap) && !freeze) begin
                    state_d = SEQ;
                    ptr_d   = 3'd0;
                end else if (|fpend_q && !freeze) begin
                    state_d = FORCE;
                end
            end
            SEQ: begin
                if (en_ext[ptr_q]) begin
                    stb_d  = ONE << ptr_q;
                    ch_d   = ptr_q;
                    rand_d = lfsr_q[7:0];
                    lfsr_d = lfsr_nxt;
                    clr    = ONE << ptr_q;
                end
                if (ptr_q == LAST) begin
                    seq_done = 1'b1;
                    ec_d     = ec_q + 16'd1;
                    state_d  = IDLE;
                end else begin
                    ptr_d = ptr_q + 3'd1;
                end
            end
            FORCE: begin
                if (found) begin
                    clr = ONE << gnt;
                    if (en_ext[gnt]) begin
                        stb_d  = ONE << gnt;
                        ch_d   = gnt;
                        rand_d = lfsr_q[7:0];
                        lfsr_d = lfsr_nxt;
                    end
                    rr_d = (gnt == LAST) ? 3'd0 : gnt + 3'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pend_d = pend_q;
        if (seq_done) pend_d = 1'b0;
        if (wrap && !pend_q) pend_d = 1'b1;
        ovr_d   = ovr_q | (wrap & pend_q);
        // A request arriving in the cycle its bit is served re-arms it.
        fpend_d = (fpend_q & ~clr) | force_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            fpend_q <= '0;
            rr_q    <= '0;
            ptr_q   <= '0;
            lfsr_q  <= SEED;
            stb_q   <= '0;
            ch_q    <= '0;
            rand_q  <= '0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            fpend_q <= fpend_d;
            rr_q    <= rr_d;
            ptr_q   <= ptr_d;
            lfsr_q  <= lfsr_d;
            stb_q   <= stb_d;
            ch_q    <= ch_d;
            rand_q  <= rand_d;
            ec_q    <= ec_d;
        end
    end

    assign upd_stb     = stb_q;
    assign upd_ch      = ch_q;
    assign upd_rand    = rand_q;
    assign busy        = (state_q != IDLE);
    assign epoch_count = ec_q;
    assign overrun     = ovr_q;
endmodule

// File: doc/drift_update_scheduler.md
Name: drift_update_scheduler

Overview:
- Central sequencer for the per-oscillator frequency-drift random walks (theta, alpha, SR, cortical).
- Replaces per-module update counters and LFSRs with a single epoch timer and a shared 16-bit LFSR.
- Issues staggered, one-hot update strobes plus a random byte to each enabled drift channel.
- Arbitrates asynchronous forced-update requests round-robin, so all drifts step coherently once per epoch.

Parameters:
- NUM_CH, 4, number of drift channels (2..8).
- PERIOD, 800, clk_en ticks per epoch (0.2 s at 4 kHz); legal range 2..2^22-1.
- LFSR_SEED, 16'hC3A7, shared LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  4 kHz sample enable; advances the epoch timer only.
- freeze  in  1  halts the epoch timer and blocks new grants.
- ch_enable  in  NUM_CH  per-channel participation mask.
- force_req  in  NUM_CH  single-cycle pulses requesting an extra update.
- upd_stb  out  NUM_CH  registered one-hot update strobe, one clk wide.
- upd_ch  out  3  index of the strobed channel (valid with upd_stb).
- upd_rand  out  8  lfsr[7:0] sampled at grant (bit0 = direction, bit1 = step size).
- busy  out  1  high while in SEQ or FORCE.
- epoch_count  out  16  completed epochs, wraps at 65535 -> 0.
- overrun  out  1  sticky; set when an epoch expires while the previous one is still pending.

Behaviour:
- Reset (async): timer=0, epoch_pending=0, force_pend=0, rr_ptr=0, ptr=0, lfsr=seed, state=IDLE; all outputs 0.
- Epoch timer:
  - Increments on clk_en when freeze=0.
  - At PERIOD-1 it wraps to 0 and sets epoch_pending.
  - If epoch_pending is already set at that wrap, it sets overrun and does not queue a second epoch.
- force_req[i]=1 sets force_pend[i]; pending requests are held until served.
- FSM states: IDLE, SEQ, FORCE.
- IDLE:
  - Priority 1: epoch_pending && !freeze -> SEQ, ptr=0.
  - Priority 2: else |force_pend && !freeze -> FORCE.
  - Otherwise remain in IDLE.
- SEQ (exactly NUM_CH clk cycles):
  - Each cycle with ch_enable[ptr]=1 registers upd_stb=1<<ptr, upd_ch=ptr, upd_rand=lfsr[7:0], advances the LFSR, and clears force_pend[ptr] (the epoch update satisfies it). Any force_req[ptr] arriving in that same cycle wins and re-sets force_pend[ptr].
  - Disabled channels produce upd_stb=0 and no LFSR step.
  - At ptr=NUM_CH-1: clear epoch_pending, increment epoch_count, return to IDLE.
- FORCE (one cycle):
  - Grants the first set bit of force_pend searching from rr_ptr upward with wrap.
  - Strobes only if ch_enable is set for that channel; clears its bit regardless.
  - Sets rr_ptr = granted+1 mod NUM_CH, then returns to IDLE.
- Latency: the clk_en cycle that wraps the timer is cycle T. SEQ occupies T+1..T+NUM_CH. Strobe for channel k appears at cycle T+2+k.
- LFSR: polynomial x^16+x^14+x^13+x^11+1, shift-left with feedback into bit0. It steps only on an issued strobe, so outputs are deterministic for a given enable pattern.
- freeze:
  - Asserted mid-SEQ or mid-FORCE: the current operation completes.
  - Blocks new grants and holds the timer value.
  - Pending flags persist through freeze.
- upd_stb is never high for two channels in the same cycle. Outputs other than upd_stb hold their last value.
- ch_enable is sampled per cycle; a change mid-SEQ affects only channels not yet visited.
- Reset mid-SEQ aborts the sequence. No strobe is issued in the cycle after rst is released unless a new grant occurs.

Test Plan:
- Basic epoch: PERIOD=8, NUM_CH=4, all enabled, clk_en every clk -> strobes 0001,0010,0100,1000 on clks 9..12 after reset release; epoch_count=1; upd_rand values equal successive lfsr[7:0] from seed C3A7 (first = A7).
- Masking: ch_enable=4'b0101 -> only ch0 and ch2 strobe within the 4-cycle SEQ window; the LFSR advances twice; the second epoch's first upd_rand equals the third LFSR state.
- Force round-robin: force_req=4'b1010 pulsed during IDLE, rr_ptr=0 -> ch1 strobes, then ch3 on the next FORCE; rr_ptr ends at 0. Repeating with rr_ptr=2 grants ch3 first.
- Epoch priority and merge: force_req[2] set in the same cycle the epoch becomes pending -> SEQ runs first, ch2 strobes exactly once, and force_pend becomes 0.
- Overrun/freeze: PERIOD=2 with freeze held during a pending epoch for 3 clk_en ticks -> the timer does not advance and overrun stays 0. Then drive PERIOD=2 with clk_en every clk and NUM_CH=4 -> overrun becomes 1 and epoch_count increments once per completed SEQ only.
- Async reset mid-SEQ: assert rst after the ch1 strobe -> all outputs 0 immediately, and the next epoch starts again from ch0 with upd_rand=A7.
